// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults), derived totals,
// controller state encoding and the registered output bundle.
package vga_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_QUALIFY   = 3'd1,
    ST_IDLE      = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } vga_state_e;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic [9:0] x;
    logic [9:0] y;
  } vga_out_t;
endpackage

// File: rtl/vga_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module vga_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= 2'b00;
    else        sr <= {sr[0], d};
  end

  assign q = sr[1];
endmodule

// File: rtl/vga_timing.sv
// VGA timing generator with PLL-lock qualification and frame-completing drain.
// Optional sticky lock-loss flag enabled by defining VGA_TIMING_LOCKLOSS_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE         = H_ACTIVE_D,
  parameter int H_FP             = H_FP_D,
  parameter int H_SYNC           = H_SYNC_D,
  parameter int H_BP             = H_BP_D,
  parameter int V_ACTIVE         = V_ACTIVE_D,
  parameter int V_FP             = V_FP_D,
  parameter int V_SYNC           = V_SYNC_D,
  parameter int V_BP             = V_BP_D,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int LOCK_WAIT        = 16
) (
  input  logic       clock_in,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       enable,
  input  logic       clear_lost,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running,
  output logic       lock_lost
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int         QW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_WAIT - 1);
  localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

  logic          lk;
  vga_state_e    st, st_n;
  logic [9:0]    h, v, h_n, v_n, h_adv, v_adv;
  logic [QW-1:0] q_cnt, q_n;
  logic          vid_n;
  vga_out_t      o_q, o_n;
  logic          run_q;

  vga_sync2 u_lock_sync (
    .clk   (clock_in),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  always_comb begin
    st_n  = st;
    h_n   = h;
    v_n   = v;
    q_n   = q_cnt;
    h_adv = (h == H_LAST) ? 10'd0 : h + 10'd1;
    v_adv = (h != H_LAST) ? v : ((v == V_LAST) ? 10'd0 : v + 10'd1);
    case (st)
      ST_WAIT_LOCK: begin
        h_n = '0;
        v_n = '0;
        q_n = '0;
        if (lk) st_n = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (q_cnt == Q_LAST) st_n = ST_IDLE;
        else                 q_n  = q_cnt + QW'(1);
      end
      ST_IDLE: if (enable) st_n = ST_RUN;
      ST_RUN, ST_DRAIN: begin
        h_n = h_adv;
        v_n = v_adv;
        // Without enable, keep scanning until the last pixel of the frame.
        if (enable)                             st_n = ST_RUN;
        else if (h == H_LAST && v == V_LAST)    st_n = ST_IDLE;
        else                                    st_n = ST_DRAIN;
      end
      default: st_n = ST_WAIT_LOCK;
    endcase
    if (!lk && st != ST_WAIT_LOCK) begin
      st_n = ST_WAIT_LOCK;
      h_n  = '0;
      v_n  = '0;
      q_n  = '0;
    end
  end

  // Outputs are registered from next-state values so they line up with st/h/v.
  always_comb begin
    vid_n         = (st_n == ST_RUN) || (st_n == ST_DRAIN);
    o_n.hsync     = (vid_n && h_n >= HS_LO && h_n < HS_HI) ? SYNC_ON : ~SYNC_ON;
    o_n.vsync     = (vid_n && v_n >= VS_LO && v_n < VS_HI) ? SYNC_ON : ~SYNC_ON;
    o_n.active    = vid_n && (h_n < H_ACT) && (v_n < V_ACT);
    o_n.line_start  = vid_n && (h_n == 10'd0);
    o_n.frame_start = vid_n && (h_n == 10'd0) && (v_n == 10'd0);
    o_n.x         = vid_n ? h_n : 10'd0;
    o_n.y         = vid_n ? v_n : 10'd0;
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_WAIT_LOCK;
      h     <= '0;
      v     <= '0;
      q_cnt <= '0;
      run_q <= 1'b0;
      o_q   <= '{hsync: ~SYNC_ON, vsync: ~SYNC_ON, default: '0};
    end else begin
      st    <= st_n;
      h     <= h_n;
      v     <= v_n;
      q_cnt <= q_n;
      run_q <= vid_n;
      o_q   <= o_n;
    end
  end

  assign hsync       = o_q.hsync;
  assign vsync       = o_q.vsync;
  assign active      = o_q.active;
  assign line_start  = o_q.line_start;
  assign frame_start = o_q.frame_start;
  assign x           = o_q.x;
  assign y           = o_q.y;
  assign running     = run_q;

`ifdef VGA_TIMING_LOCKLOSS_EN
  logic lost_q;
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n)                                          lost_q <= 1'b0;
    else if (!lk && (st == ST_RUN || st == ST_DRAIN))    lost_q <= 1'b1;
    else if (clear_lost)                                 lost_q <= 1'b0;
  end
  assign lock_lost = lost_q;
`else
  logic unused_clear;
  assign unused_clear = clear_lost;
  assign lock_lost    = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a reduced raster and a
// pixel-index reference model of the scan position.
module tb_vga_timing;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int LW = 16;
`ifdef VGA_TIMING_LOCKLOSS_EN
  localparam logic EXP_LL = 1'b1;
`else
  localparam logic EXP_LL = 1'b0;
`endif
  localparam logic [25:0] RST_VEC = {1'b0, 1'b1, 1'b1, 3'b000, 20'd0};

  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, enable = 1'b0, clear_lost = 1'b0;
  logic hsync, vsync, active, line_start, frame_start, running, lock_lost;
  logic [9:0] x, y;
  logic [25:0] obs;
  int checks = 0, errors = 0;
  bit m_on = 1'b0, m_ready = 1'b0;
  int m_p = 0;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE_HIGH(0), .LOCK_WAIT(LW)
  ) dut (
    .clock_in(clk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(enable),
    .clear_lost(clear_lost), .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .running(running), .lock_lost(lock_lost)
  );

  assign obs = {running, hsync, vsync, active, line_start, frame_start, x, y};

  // Expected outputs from the scan position: pixel index within the frame.
  function automatic logic [25:0] exp_vec();
    int ex, ey;
    logic hs, vs, act, ls, fs;
    ex  = m_on ? m_p % HT : 0;
    ey  = m_on ? m_p / HT : 0;
    act = m_on && ex < HA && ey < VA;
    hs  = !(m_on && ex >= HA + HFP && ex < HA + HFP + HS);
    vs  = !(m_on && ey >= VA + VFP && ey < VA + VFP + VS);
    ls  = m_on && ex == 0;
    fs  = m_on && m_p == 0;
    return {m_on, hs, vs, act, ls, fs, 10'(ex), 10'(ey)};
  endfunction

  function automatic int mx(); return m_on ? m_p % HT : 0; endfunction
  function automatic int my(); return m_on ? m_p / HT : 0; endfunction

  // One clock: model sees enable at the edge exactly as the DUT does.
  task automatic model_edge();
    @(posedge clk);
    if (m_on) begin
      if (m_p == FT - 1 && !enable) m_on = 1'b0;
      else                          m_p  = (m_p + 1) % FT;
    end else if (m_ready && enable) begin
      m_on = 1'b1;
      m_p  = 0;
    end
    @(negedge clk);
  endtask

  task automatic wait_running(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (running) begin n = i; break; end
    end
    if (n > 0) begin m_on = 1'b1; m_ready = 1'b1; m_p = 0; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    enable     = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_outputs obs %h exp %h", obs, RST_VEC);
    end
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++; $display("FAIL reset_lock_lost obs %b exp 0", lock_lost);
    end
  endtask

  task automatic test_qualify();
    int n;
    rst_n = 1'b1;
    wait_running(n);
    checks++;
    if (n < 2 + LW || n > 2 + LW + 2) begin
      errors++; $display("FAIL qualify_latency obs %0d exp 18..20", n);
    end
  endtask

  task automatic test_frame();
    int last_ls = -1, last_fs = -1, ls_bad = 0, fs_per = -1;
    int hs_low = 0, hs_first = -1, vs_low = 0, act_cnt = 0;
    for (int t = 0; t < 2 * FT; t++) begin
      if (t > 0) model_edge();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL frame_cycle t %0d obs %h exp %h", t, obs, exp_vec());
      end
      if (t < FT) begin
        if (!vsync) vs_low++;
        if (active) act_cnt++;
      end
      if (t < HT && !hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (line_start) begin
        if (last_ls >= 0 && t - last_ls != HT) ls_bad++;
        last_ls = t;
      end
      if (frame_start) begin
        if (last_fs >= 0) fs_per = t - last_fs;
        last_fs = t;
      end
    end
    checks++;
    if (hs_low != HS) begin errors++; $display("FAIL hsync_width obs %0d exp %0d", hs_low, HS); end
    checks++;
    if (hs_first != HA + HFP) begin errors++; $display("FAIL hsync_start obs %0d exp %0d", hs_first, HA + HFP); end
    checks++;
    if (ls_bad != 0 || last_ls < HT) begin errors++; $display("FAIL line_period bad %0d last %0d exp period %0d", ls_bad, last_ls, HT); end
    checks++;
    if (fs_per != FT) begin errors++; $display("FAIL frame_period obs %0d exp %0d", fs_per, FT); end
    checks++;
    if (vs_low != VS * HT) begin errors++; $display("FAIL vsync_width obs %0d exp %0d", vs_low, VS * HT); end
    checks++;
    if (act_cnt != HA * VA) begin errors++; $display("FAIL active_count obs %0d exp %0d", act_cnt, HA * VA); end
  endtask

  task automatic test_enable_drop();
    int px = -1, py = -1, fs_cnt = 0, guard = 0;
    while (!(m_on && my() == 5 && mx() == 0) && guard < 2 * FT) begin
      model_edge(); guard++;
    end
    enable = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      if (running) begin px = int'(x); py = int'(y); end
      model_edge();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL drain_cycle i %0d obs %h exp %h", i, obs, exp_vec());
      end
      if (!m_on) break;
    end
    checks++;
    if (px != HT - 1 || py != VT - 1 || running !== 1'b0) begin
      errors++; $display("FAIL drain_last obs x %0d y %0d run %b exp x %0d y %0d run 0", px, py, running, HT - 1, VT - 1);
    end
    for (int i = 0; i < 2 * FT; i++) begin
      model_edge();
      if (frame_start) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 0 || obs !== exp_vec()) begin
      errors++; $display("FAIL idle_after_drain fs %0d obs %h exp %h", fs_cnt, obs, exp_vec());
    end
    enable = 1'b1;
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      model_edge();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_cycle i %0d en %b obs %h exp %h", i, enable, obs, exp_vec());
      end
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      clear_lost = ($urandom_range(0, 7) == 0);
    end
    enable     = 1'b1;
    clear_lost = 1'b0;
  endtask

  task automatic test_lock_loss();
    int n, guard = 0;
    while (!(m_on && my() == 5 && mx() == 3) && guard < 3 * FT) begin
      model_edge(); guard++;
    end
    checks++;
    if (!m_on || running !== 1'b1) begin
      errors++; $display("FAIL lockloss_setup run %b exp 1", running);
    end
    pll_locked = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    m_on = 1'b0; m_ready = 1'b0;
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL lockloss_outputs obs %h exp %h", obs, RST_VEC);
    end
    checks++;
    if (lock_lost !== EXP_LL) begin
      errors++; $display("FAIL lockloss_flag obs %b exp %b", lock_lost, EXP_LL);
    end
    clear_lost = 1'b1;
    @(negedge clk);
    clear_lost = 1'b0;
    @(negedge clk);
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++; $display("FAIL lockloss_clear obs %b exp 0", lock_lost);
    end
    pll_locked = 1'b1;
    wait_running(n);
    checks++;
    if (n < 2 + LW || n > 2 + LW + 2) begin
      errors++; $display("FAIL relock_latency obs %0d exp 18..20", n);
    end
  endtask

  task automatic test_glitch();
    int n, early = 0;
    rst_n = 1'b0; m_on = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); @(negedge clk); if (running) early++; end
    pll_locked = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); if (running) early++; end
    pll_locked = 1'b1;
    wait_running(n);
    checks++;
    if (early != 0) begin errors++; $display("FAIL glitch_early_run obs %0d exp 0", early); end
    checks++;
    if (n < 2 + LW || n > 2 + LW + 2) begin
      errors++; $display("FAIL glitch_restart obs %0d exp 18..20", n);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL glitch_first_run obs %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int n;
    repeat (10) model_edge();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL pre_reset obs %h exp %h", obs, exp_vec());
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC || lock_lost !== 1'b0) begin
      errors++; $display("FAIL async_reset obs %h ll %b exp %h ll 0", obs, lock_lost, RST_VEC);
    end
    m_on = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_running(n);
    checks++;
    if (n < 2 + LW || n > 2 + LW + 2) begin
      errors++; $display("FAIL post_reset_latency obs %0d exp 18..20", n);
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_frame();
    test_enable_drop();
    test_random_enable();
    test_lock_loss();
    test_glitch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
